exe_muldiv_iter: RTL and testbench
==================================

Name: exe_muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the RV32M/RV64M extension.
- Successor to the fixed-width, fixed-latency M-type execute helper.
- Sits beside the I/R/L-S/B-J execute sub-units inside the execute stage and asserts a stall request toward pipe_ctrl while an operation is in flight.
- Adds configurable width and multiply radix, one-cycle early completion of divide special cases, flush/abort, and quotient/remainder result reuse.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- MUL_STEP_BITS, 1, multiplier bits consumed per cycle; one of 1, 2, 4; must divide XLEN.
- DIV_EARLY_OUT, 1, 1 = divide-by-zero and signed overflow finish in one cycle.
- DIV_REUSE, 1, 1 = a DIV/REM pair (or DIVU/REMU pair) with identical operands reuses the last result.

Ports:
- clk_in  input  1  clock, rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  M-type instruction present in execute (opcode R_M, funct7=0000001).
- op_in  input  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- op1_in  input  XLEN  rs1 value.
- op2_in  input  XLEN  rs2 value.
- reg_waddr_in  input  5  destination register.
- flush_in  input  1  pipeline flush; aborts any operation.
- stall_req_out  output  1  stall request to pipe_ctrl.
- busy_out  output  1  state is not IDLE.
- result_valid_out  output  1  one-cycle result pulse.
- reg_wdata_out  output  XLEN  result.
- reg_waddr_out  output  5  destination for the result.
- reg_we_out  output  1  write enable (equals result_valid_out).

Behaviour:
- Reset: state IDLE; all outputs 0; reuse cache invalid. Reset mid-operation aborts with no result.
- States and transitions:
  - IDLE: on start_in & ~flush_in, latch op, operands and waddr, then:
    - MUL op -> MUL state;
    - DIV op with early-out condition (DIV_EARLY_OUT=1) -> DONE;
    - DIV op with reuse hit (DIV_REUSE=1) -> DONE;
    - otherwise DIV op -> DIV state.
  - MUL: XLEN/MUL_STEP_BITS shift-add cycles on 2*XLEN magnitude product, then DONE.
  - DIV: XLEN restoring-division cycles on magnitudes, then DONE.
  - DONE: apply sign fixup, select product half or quotient/remainder, pulse result_valid_out/reg_we_out, return to IDLE.
- Latency (start cycle = cycle 0, DONE at cycle L):
  - MUL: L = XLEN/MUL_STEP_BITS + 1.
  - DIV: L = XLEN + 1.
  - Early-out or reuse: L = 1.
- stall_req_out = (start_in & state==IDLE & ~flush_in) | (busy_out & state!=DONE). It is low in DONE so the pipeline advances exactly when the result is valid.
- start_in while busy_out is ignored; the operands latched at cycle 0 are used throughout.
- Signedness:
  - MUL: low XLEN bits.
  - MULH: signed×signed high. MULHSU: signed×unsigned high. MULHU: unsigned high.
  - Magnitudes are computed unsigned; the 2*XLEN product is negated when the operand signs differ under the op's signedness.
- Divide special cases:
  - Divisor 0: quotient all-ones, remainder = dividend (signed and unsigned).
  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend, remainder 0.
  - With DIV_EARLY_OUT=0, these take the full iterative path and must still produce the same values.
- Remainder sign follows the dividend; quotient is negated if signs differ and divisor ≠ 0.
- Reuse cache:
  - Updated at every completed divide with op1, op2, signedness, quotient and remainder.
  - Hit requires equal op1, op2 and signedness; the current op may be DIV or REM.
  - Invalidated by flush_in or reset.
- flush_in in any state: next state IDLE, no result_valid_out, stall_req_out low in that same cycle. flush_in together with start_in in IDLE: start is ignored.
- rd = x0: result is computed; reg_we_out pulses with reg_waddr_out = 0. Writeback discards it.

Test Plan:
- XLEN=32, MUL_STEP_BITS=1: MUL 7×-3 -> after 33 cycles reg_wdata_out=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF. stall_req_out high for cycles 0..32, low at 33.
- MUL_STEP_BITS=4: MULH 0x80000000×0x80000000 -> 0x40000000 at cycle 9.
- DIV -7/2 -> 0xFFFFFFFD (cycle 33); then REM -7/2 with same operands -> 0xFFFFFFFF at cycle 1 (reuse hit). DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC at cycle 33 (no hit, signedness differs).
- DIV x/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each at cycle 1. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, each at cycle 1. Repeat with DIV_EARLY_OUT=0 -> same values at cycle 33.
- flush_in at cycle 10 of DIV -> no result_valid_out, busy_out=0 next cycle; a following REM with same operands takes the full 33 cycles (cache invalidated).
- reset_n_in low at cycle 5 of MUL -> all outputs 0 asynchronously. start_in pulsed at cycles 3..20 of an active DIV -> ignored, single result.

Source files
------------

// File: rtl/exe_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// optional one-cycle divide special cases and quotient/remainder reuse.
module exe_muldiv_iter #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MUL_STEP_BITS = 1,
  parameter bit          DIV_EARLY_OUT = 1'b1,
  parameter bit          DIV_REUSE     = 1'b1
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            start_in,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] op1_in,
  input  logic [XLEN-1:0] op2_in,
  input  logic [4:0]      reg_waddr_in,
  input  logic            flush_in,
  output logic            stall_req_out,
  output logic            busy_out,
  output logic            result_valid_out,
  output logic [XLEN-1:0] reg_wdata_out,
  output logic [4:0]      reg_waddr_out,
  output logic            reg_we_out
);

  localparam int unsigned MulCycles = XLEN / MUL_STEP_BITS;
  localparam int unsigned CntW      = $clog2(XLEN) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q;
  logic [4:0]        waddr_q;
  logic [XLEN-1:0]   op1_q, op2_q;
  logic              neg_q, a_neg_q, hit_q;
  logic [CntW-1:0]   cnt_q;
  logic [2*XLEN-1:0] prod_q, mcand_q;
  logic [XLEN-1:0]   mplier_q, quo_q, rem_q, dvsr_q;

  logic              c_valid_q, c_signed_q;
  logic [XLEN-1:0]   c_op1_q, c_op2_q, c_quo_q, c_rem_q;

  // Operand decode at issue
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, early, hit, accept;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = op_in[2] ? ~op_in[0] : (op_in[1:0] != 2'b11);
    b_signed = op_in[2] ? ~op_in[0] : (op_in[1] == 1'b0);
    a_neg    = a_signed & op1_in[XLEN-1];
    b_neg    = b_signed & op2_in[XLEN-1];
    a_mag    = a_neg ? -op1_in : op1_in;
    b_mag    = b_neg ? -op2_in : op2_in;
    div_zero = (op2_in == '0);
    div_ovf  = ~op_in[0] & (op1_in == {1'b1, {(XLEN-1){1'b0}}}) & (op2_in == '1);
    early    = DIV_EARLY_OUT & (div_zero | div_ovf);
    hit      = DIV_REUSE & c_valid_q & (c_op1_q == op1_in) & (c_op2_q == op2_in) &
               (c_signed_q == ~op_in[0]);
    accept   = (state_q == StIdle) & start_in & ~flush_in;
  end

  // Iteration datapath
  logic [2*XLEN-1:0] digit_ext;
  logic [XLEN:0]     rem_sh, diff;
  logic              ge;

  always_comb begin
    digit_ext = '0;
    digit_ext[MUL_STEP_BITS-1:0] = mplier_q[MUL_STEP_BITS-1:0];
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    ge     = (rem_sh >= {1'b0, dvsr_q});
  end

  // Sign fixup and result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_sel, rem_sel, result;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_sel  = hit_q ? c_quo_q : (neg_q ? -quo_q : quo_q);
    rem_sel  = hit_q ? c_rem_q : (a_neg_q ? -rem_q : rem_q);
    if (op_q[2])                result = op_q[1] ? rem_sel : quo_sel;
    else if (op_q[1:0] == 2'b00) result = prod_fix[XLEN-1:0];
    else                        result = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = !op_in[2] ? StMul : ((early || hit) ? StDone : StDiv);
      StMul:  if (cnt_q == '0) state_d = StDone;
      StDiv:  if (cnt_q == '0) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_in) state_d = StIdle;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= StIdle;
      op_q     <= '0;
      waddr_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      hit_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= op_in;
        waddr_q  <= reg_waddr_in;
        op1_q    <= op1_in;
        op2_q    <= op2_in;
        a_neg_q  <= a_neg;
        hit_q    <= op_in[2] & hit & ~early;
        neg_q    <= (a_neg ^ b_neg) & ~(op_in[2] & div_zero);
        cnt_q    <= op_in[2] ? CntW'(XLEN - 1) : CntW'(MulCycles - 1);
        prod_q   <= '0;
        mcand_q  <= {{XLEN{1'b0}}, a_mag};
        mplier_q <= b_mag;
        dvsr_q   <= b_mag;
        // Early-out preloads final magnitudes so the normal sign fixup applies
        if (early) begin
          quo_q <= div_zero ? '1 : a_mag;
          rem_q <= div_zero ? a_mag : '0;
        end else begin
          quo_q <= a_mag;
          rem_q <= '0;
        end
      end else if (state_q == StMul) begin
        prod_q   <= prod_q + mcand_q * digit_ext;
        mcand_q  <= mcand_q << MUL_STEP_BITS;
        mplier_q <= mplier_q >> MUL_STEP_BITS;
        cnt_q    <= cnt_q - 1'b1;
      end else if (state_q == StDiv) begin
        rem_q <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      c_valid_q  <= 1'b0;
      c_signed_q <= 1'b0;
      c_op1_q    <= '0;
      c_op2_q    <= '0;
      c_quo_q    <= '0;
      c_rem_q    <= '0;
    end else if (flush_in) begin
      c_valid_q <= 1'b0;
    end else if (state_q == StDone && op_q[2]) begin
      c_valid_q  <= 1'b1;
      c_signed_q <= ~op_q[0];
      c_op1_q    <= op1_q;
      c_op2_q    <= op2_q;
      c_quo_q    <= quo_sel;
      c_rem_q    <= rem_sel;
    end
  end

  logic done_ok;

  always_comb begin
    done_ok          = (state_q == StDone) & ~flush_in;
    busy_out         = (state_q != StIdle);
    stall_req_out    = accept | (busy_out & (state_q != StDone) & ~flush_in);
    result_valid_out = done_ok;
    reg_we_out       = done_ok;
    reg_wdata_out    = done_ok ? result : '0;
    reg_waddr_out    = done_ok ? waddr_q : '0;
  end

endmodule

// File: tb/tb_exe_muldiv_iter.sv
// Directed bench for exe_muldiv_iter: three configurations checked against hand-computed results.
module tb_exe_muldiv_iter;

  localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  op_r;
  logic [31:0] op1_r, op2_r;
  logic [4:0]  waddr_r;
  logic        flush_r;

  logic [2:0]  stall_v, busy_v, valid_v, we_v;
  logic [31:0] data_v [3];
  logic [4:0]  wa_v [3];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // u0: radix-1 with early-out and reuse; u1: radix-4; u2: no early-out, no reuse
  exe_muldiv_iter #(.XLEN(32), .MUL_STEP_BITS(1), .DIV_EARLY_OUT(1'b1), .DIV_REUSE(1'b1)) u0 (
    .clk_in(clk), .reset_n_in(rst_n), .start_in(start_v[0]), .op_in(op_r), .op1_in(op1_r),
    .op2_in(op2_r), .reg_waddr_in(waddr_r), .flush_in(flush_r), .stall_req_out(stall_v[0]),
    .busy_out(busy_v[0]), .result_valid_out(valid_v[0]), .reg_wdata_out(data_v[0]),
    .reg_waddr_out(wa_v[0]), .reg_we_out(we_v[0]));

  exe_muldiv_iter #(.XLEN(32), .MUL_STEP_BITS(4), .DIV_EARLY_OUT(1'b1), .DIV_REUSE(1'b1)) u1 (
    .clk_in(clk), .reset_n_in(rst_n), .start_in(start_v[1]), .op_in(op_r), .op1_in(op1_r),
    .op2_in(op2_r), .reg_waddr_in(waddr_r), .flush_in(flush_r), .stall_req_out(stall_v[1]),
    .busy_out(busy_v[1]), .result_valid_out(valid_v[1]), .reg_wdata_out(data_v[1]),
    .reg_waddr_out(wa_v[1]), .reg_we_out(we_v[1]));

  exe_muldiv_iter #(.XLEN(32), .MUL_STEP_BITS(1), .DIV_EARLY_OUT(1'b0), .DIV_REUSE(1'b0)) u2 (
    .clk_in(clk), .reset_n_in(rst_n), .start_in(start_v[2]), .op_in(op_r), .op1_in(op1_r),
    .op2_in(op2_r), .reg_waddr_in(waddr_r), .flush_in(flush_r), .stall_req_out(stall_v[2]),
    .busy_out(busy_v[2]), .result_valid_out(valid_v[2]), .reg_wdata_out(data_v[2]),
    .reg_waddr_out(wa_v[2]), .reg_we_out(we_v[2]));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op on instance idx and watch a fixed 40-cycle window. Between cycles hlo..hhi
  // start is re-asserted with different operands, which a busy unit must ignore.
  task automatic run_op(input string tag, input int idx, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa,
                        input int hlo, input int hhi,
                        input logic [31:0] exp_data, input int exp_lat);
    int lat, nval, cbad;
    logic [31:0] data;
    logic [4:0]  wao;
    lat = -1; nval = 0; cbad = 0; data = '0; wao = '0;
    @(negedge clk);
    op_r = op; op1_r = a; op2_r = b; waddr_r = wa;
    start_v = '0; start_v[idx] = 1'b1;
    #1;
    if (!stall_v[idx]) cbad++;
    @(posedge clk); #1;
    start_v = '0;
    for (int c = 1; c <= 40; c++) begin
      if (we_v[idx] !== valid_v[idx]) cbad++;
      if (valid_v[idx]) begin
        nval++;
        if (stall_v[idx]) cbad++;
        if (lat < 0) begin
          lat = c; data = data_v[idx]; wao = wa_v[idx];
        end
      end else if (lat < 0 && !stall_v[idx]) begin
        cbad++;
      end
      if (c >= hlo && c <= hhi) begin
        start_v[idx] = 1'b1; op_r = OpMul; op1_r = a + 32'(c);
      end else begin
        start_v[idx] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_v = '0;
    check_val({tag, " data"}, 64'(data), 64'(exp_data));
    check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, " pulses"}, 64'(nval), 64'd1);
    check_val({tag, " waddr"}, 64'(wao), 64'(wa));
    check_val({tag, " stall/we"}, 64'(cbad), 64'd0);
  endtask

  initial begin
    int nv;
    rst_n = 1'b0; start_v = '0; op_r = '0; op1_r = '0; op2_r = '0; waddr_r = '0;
    flush_r = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset ctl", 64'({stall_v[0], busy_v[0], valid_v[0], we_v[0]}), 64'd0);
    check_val("reset data", 64'(data_v[0]), 64'd0);
    check_val("reset waddr", 64'(wa_v[0]), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Multiply
    run_op("mul 7x-3", 0, OpMul, 32'd7, 32'hFFFF_FFFD, 5'd3, 0, -1, 32'hFFFF_FFEB, 33);
    run_op("mulhu", 0, OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, -1, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 0, OpMulhsu, 32'hFFFF_FFFF, 32'd2, 5'd5, 0, -1, 32'hFFFF_FFFF, 33);
    run_op("mulh r4", 1, OpMulh, 32'h8000_0000, 32'h8000_0000, 5'd6, 0, -1, 32'h4000_0000, 9);
    run_op("mul r4", 1, OpMul, 32'd1000, 32'd1000, 5'd6, 0, -1, 32'd1000000, 9);

    // Divide and reuse
    run_op("div -7/2", 0, OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, -1, 32'hFFFF_FFFD, 33);
    run_op("rem -7/2 hit", 0, OpRem, 32'hFFFF_FFF9, 32'd2, 5'd8, 0, -1, 32'hFFFF_FFFF, 1);
    run_op("divu miss", 0, OpDivu, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, -1, 32'h7FFF_FFFC, 33);

    // Special cases, early-out
    run_op("div x/0", 0, OpDiv, 32'd5, 32'd0, 5'd10, 0, -1, 32'hFFFF_FFFF, 1);
    run_op("remu 5/0", 0, OpRemu, 32'd5, 32'd0, 5'd0, 0, -1, 32'd5, 1);
    run_op("div ovf", 0, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, -1, 32'h8000_0000, 1);
    run_op("rem ovf", 0, OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, -1, 32'd0, 1);
    run_op("rem -7/0", 0, OpRem, 32'hFFFF_FFF9, 32'd0, 5'd13, 0, -1, 32'hFFFF_FFF9, 1);

    // Same special cases on the full iterative path
    run_op("div x/0 it", 2, OpDiv, 32'd5, 32'd0, 5'd10, 0, -1, 32'hFFFF_FFFF, 33);
    run_op("remu 5/0 it", 2, OpRemu, 32'd5, 32'd0, 5'd14, 0, -1, 32'd5, 33);
    run_op("div ovf it", 2, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0, -1,
           32'h8000_0000, 33);
    run_op("rem ovf it", 2, OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0, -1, 32'd0, 33);
    run_op("rem -7/0 it", 2, OpRem, 32'hFFFF_FFF9, 32'd0, 5'd17, 0, -1, 32'hFFFF_FFF9, 33);

    // Flush mid-divide invalidates the reuse cache
    run_op("div 100/7", 0, OpDiv, 32'd100, 32'd7, 5'd18, 0, -1, 32'd14, 33);
    nv = 0;
    @(negedge clk);
    op_r = OpDiv; op1_r = 32'd50; op2_r = 32'd3; waddr_r = 5'd19; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    for (int c = 1; c < 10; c++) begin
      if (valid_v[0]) nv++;
      @(posedge clk); #1;
    end
    flush_r = 1'b1;
    #1;
    check_val("flush stall", 64'(stall_v[0]), 64'd0);
    check_val("flush valid", 64'(valid_v[0]), 64'd0);
    @(posedge clk); #1;
    flush_r = 1'b0;
    check_val("flush busy", 64'(busy_v[0]), 64'd0);
    for (int c = 0; c < 40; c++) begin
      if (valid_v[0]) nv++;
      @(posedge clk); #1;
    end
    check_val("flush no result", 64'(nv), 64'd0);
    run_op("rem after flush", 0, OpRem, 32'd100, 32'd7, 5'd20, 0, -1, 32'd2, 33);

    // Start pulses while busy are ignored
    run_op("div ignore start", 0, OpDiv, 32'd20, 32'd3, 5'd21, 3, 20, 32'd6, 33);

    // Asynchronous reset mid-multiply
    @(negedge clk);
    op_r = OpMul; op1_r = 32'd7; op2_r = 32'd9; waddr_r = 5'd22; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_val("pre-reset busy", 64'(busy_v[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("async reset ctl", 64'({stall_v[0], busy_v[0], valid_v[0], we_v[0]}), 64'd0);
    check_val("async reset data", 64'({wa_v[0], data_v[0]}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid_v[0]) nv++;
    end
    check_val("reset no result", 64'(nv), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
